rv32i_mc_control: RTL and testbench
===================================

Name: rv32i_mc_control

Overview:
- Multicycle control FSM for the RV32I datapath.
- Sequences fetch, decode and execute over several clocks, with a memory handshake.
- Drives register load enables and datapath mux selects.
- Drives imm_sel, which picks one immediate from the sign-extender's 160-bit bus. The bus packs, MSB first: I [159:128], U [127:96], B [95:64], S [63:32], J [31:0].

Parameters:
- MEM_TIMEOUT, 0, number of cycles waiting on mem_resp before entering TRAP; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- br_en  in  1  comparator result for the current branch
- mem_resp  in  1  memory completed the current read or write
- load_pc  out  1  PC register enable
- load_ir  out  1  IR enable
- load_regfile  out  1  rd write enable
- load_mar  out  1  MAR enable
- load_mdr  out  1  MDR enable
- load_data_out  out  1  store-data register enable
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_byte_en  out  4  byte enables for stores
- pcmux_sel  out  2  0 = pc+4, 1 = alu_out, 2 = alu_out & ~1
- marmux_sel  out  1  0 = pc, 1 = alu_out
- alumux1_sel  out  1  0 = rs1, 1 = pc
- alumux2_sel  out  1  0 = immediate, 1 = rs2
- imm_sel  out  3  0 = I, 1 = U, 2 = B, 3 = S, 4 = J
- regfilemux_sel  out  3  0 = alu_out, 1 = br_en, 2 = u_imm, 3 = mdr, 4 = pc+4
- trap  out  1  illegal opcode or memory timeout

Behaviour:
- Moore FSM. Every output is 0 unless the current state asserts it.
- While rst is high, all outputs are forced to 0. On the clock edge with rst high, state <= FETCH1 and the timeout counter clears. Reset mid-transaction drops mem_read/mem_write in the same cycle.
- States and transitions:
  - FETCH1: load_mar=1, marmux_sel=0. Next: FETCH2.
  - FETCH2: mem_read=1, load_mdr=1. Hold until mem_resp=1, then FETCH3.
  - FETCH3: load_ir=1. Next: DECODE.
  - DECODE: no outputs. Branches on opcode:
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 1100011 -> BR
    - 0000011 or 0100011 -> CALC_ADDR
    - 0010011 -> IMM
    - 0110011 -> REG
    - any other opcode -> TRAP
  - LUI: load_regfile=1, regfilemux_sel=2, imm_sel=1, load_pc=1. Next: FETCH1.
  - AUIPC: alumux1_sel=1, imm_sel=1, load_regfile=1, load_pc=1. Next: FETCH1.
  - IMM: imm_sel=0, load_regfile=1, load_pc=1. When funct3=010 or 011, regfilemux_sel=1. Next: FETCH1.
  - REG: alumux2_sel=1, load_regfile=1, load_pc=1. When funct3=010 or 011, regfilemux_sel=1. Next: FETCH1.
  - BR: alumux1_sel=1, imm_sel=2, load_pc=1, pcmux_sel=br_en ? 1 : 0. Next: FETCH1.
  - JAL: alumux1_sel=1, imm_sel=4, load_regfile=1, regfilemux_sel=4, load_pc=1, pcmux_sel=1. Next: FETCH1.
  - JALR: imm_sel=0, load_regfile=1, regfilemux_sel=4, load_pc=1, pcmux_sel=2. Next: FETCH1.
  - CALC_ADDR: load_mar=1, marmux_sel=1, imm_sel = (load ? 0 : 3). For stores, load_data_out=1. Next: LD1 for loads, ST1 for stores.
  - LD1: mem_read=1, load_mdr=1. Hold until mem_resp, then LD2.
  - LD2: load_regfile=1, regfilemux_sel=3, load_pc=1. Next: FETCH1.
  - ST1: mem_write=1. mem_byte_en = 0001 (funct3=000), 0011 (001), 1111 (otherwise). Hold until mem_resp, then ST2.
  - ST2: load_pc=1. Next: FETCH1.
  - TRAP: trap=1. Absorbing; only rst exits.
- Timing per instruction type:
  - ALU, LUI, AUIPC, branch and jump instructions take 5 cycles with single-cycle memory.
  - Loads and stores take 7 cycles.
- Memory wait rules:
  - mem_read or mem_write is held constant in FETCH2, LD1 and ST1 until mem_resp.
  - mem_resp received in any other state is ignored.
- Timeout:
  - When MEM_TIMEOUT > 0, a counter increments each waiting cycle and clears on state exit.
  - When the count reaches MEM_TIMEOUT with no mem_resp, the next state is TRAP.
  - If mem_resp arrives in the same cycle the count is reached, mem_resp wins.

Test Plan:
- Reset for 2 cycles, then opcode=0010011, mem_resp=1 each wait -> states FETCH1, FETCH2, FETCH3, DECODE, IMM; load_regfile=1 and imm_sel=0 on cycle 5; all outputs 0 while rst was high.
- opcode=1100011, br_en=1 then br_en=0 on a second instruction -> BR asserts imm_sel=2, pcmux_sel=1 the first time and 0 the second.
- opcode=0100011, funct3=001, mem_resp delayed 3 cycles in ST1 -> mem_write held 4 cycles, mem_byte_en=0011, CALC_ADDR imm_sel=3, return to FETCH1 after ST2.
- opcode=0000011, funct3=010 -> LD2 asserts regfilemux_sel=3, load_regfile=1; 7 total cycles.
- opcode=1101111 then opcode=1111111 -> JAL asserts imm_sel=4, regfilemux_sel=4; the illegal opcode reaches TRAP with trap=1, which persists until rst.
- MEM_TIMEOUT=4, mem_resp held 0 in FETCH2 -> TRAP after 4 wait cycles. Repeat with rst asserted during LD1 -> mem_read=0 in the same cycle and FETCH1 on the next cycle.

Source files
------------

// File: rtl/rv32i_mc_control.sv
// Multicycle control FSM for the RV32I datapath.
// Sequences fetch/decode/execute, waits on the memory handshake and drives
// register enables and datapath mux selects. Outputs are decoded from the
// current state (plus funct3/br_en where an execute state needs them) and
// are all forced low while rst is high.
module rv32i_mc_control #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_en,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_en,
    output logic [1:0] pcmux_sel,
    output logic       marmux_sel,
    output logic       alumux1_sel,
    output logic       alumux2_sel,
    output logic [2:0] imm_sel,
    output logic [2:0] regfilemux_sel,
    output logic       trap
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_U = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_S = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] RF_ALU  = 3'd0;
    localparam logic [2:0] RF_BR   = 3'd1;
    localparam logic [2:0] RF_UIMM = 3'd2;
    localparam logic [2:0] RF_MDR  = 3'd3;
    localparam logic [2:0] RF_PC4  = 3'd4;

    // Wait counter only needs to reach MEM_TIMEOUT-1; the cycle after that
    // without a response is the one that traps.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        LUI, AUIPC, JAL, JALR, BR, IMM, REG,
        CALC_ADDR, LD1, LD2, ST1, ST2,
        TRAP
    } state_t;

    typedef struct packed {
        logic       load_pc;
        logic       load_ir;
        logic       load_regfile;
        logic       load_mar;
        logic       load_mdr;
        logic       load_data_out;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_en;
        logic [1:0] pcmux_sel;
        logic       marmux_sel;
        logic       alumux1_sel;
        logic       alumux2_sel;
        logic [2:0] imm_sel;
        logic [2:0] regfilemux_sel;
        logic       trap;
    } ctl_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timed_out;
    logic          is_load;
    logic          slt_op;
    ctl_t          ctl, ctl_out;

    assign waiting   = (state == FETCH2) || (state == LD1) || (state == ST1);
    // A response in the same cycle as the last allowed wait still wins.
    assign timed_out = (MEM_TIMEOUT > 0) && waiting && !mem_resp && (wait_cnt == CNT_LAST);
    assign is_load   = (opcode == OP_LOAD);
    // SLT/SLTU write the comparator result instead of the ALU output.
    assign slt_op    = (funct3[2:1] == 2'b01);

    // State register and per-state wait counter (cleared whenever the state changes).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH1;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if ((MEM_TIMEOUT > 0) && waiting && (state_next == state))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Next-state logic and per-state control decode.
    always_comb begin
        state_next = state;
        ctl        = '0;
        case (state)
            FETCH1: begin
                ctl.load_mar = 1'b1;
                state_next   = FETCH2;
            end
            FETCH2: begin
                ctl.mem_read = 1'b1;
                ctl.load_mdr = 1'b1;
                if (mem_resp)       state_next = FETCH3;
                else if (timed_out) state_next = TRAP;
            end
            FETCH3: begin
                ctl.load_ir = 1'b1;
                state_next  = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_BR:             state_next = BR;
                    OP_LOAD, OP_STORE: state_next = CALC_ADDR;
                    OP_IMM:            state_next = IMM;
                    OP_REG:            state_next = REG;
                    default:           state_next = TRAP;
                endcase
            end
            LUI: begin
                ctl.load_regfile   = 1'b1;
                ctl.regfilemux_sel = RF_UIMM;
                ctl.imm_sel        = IMM_U;
                ctl.load_pc        = 1'b1;
                state_next         = FETCH1;
            end
            AUIPC: begin
                ctl.alumux1_sel  = 1'b1;
                ctl.imm_sel      = IMM_U;
                ctl.load_regfile = 1'b1;
                ctl.load_pc      = 1'b1;
                state_next       = FETCH1;
            end
            IMM: begin
                ctl.imm_sel        = IMM_I;
                ctl.load_regfile   = 1'b1;
                ctl.load_pc        = 1'b1;
                ctl.regfilemux_sel = slt_op ? RF_BR : RF_ALU;
                state_next         = FETCH1;
            end
            REG: begin
                ctl.alumux2_sel    = 1'b1;
                ctl.load_regfile   = 1'b1;
                ctl.load_pc        = 1'b1;
                ctl.regfilemux_sel = slt_op ? RF_BR : RF_ALU;
                state_next         = FETCH1;
            end
            BR: begin
                ctl.alumux1_sel = 1'b1;
                ctl.imm_sel     = IMM_B;
                ctl.load_pc     = 1'b1;
                ctl.pcmux_sel   = br_en ? 2'd1 : 2'd0;
                state_next      = FETCH1;
            end
            JAL: begin
                ctl.alumux1_sel    = 1'b1;
                ctl.imm_sel        = IMM_J;
                ctl.load_regfile   = 1'b1;
                ctl.regfilemux_sel = RF_PC4;
                ctl.load_pc        = 1'b1;
                ctl.pcmux_sel      = 2'd1;
                state_next         = FETCH1;
            end
            JALR: begin
                ctl.imm_sel        = IMM_I;
                ctl.load_regfile   = 1'b1;
                ctl.regfilemux_sel = RF_PC4;
                ctl.load_pc        = 1'b1;
                ctl.pcmux_sel      = 2'd2;
                state_next         = FETCH1;
            end
            CALC_ADDR: begin
                ctl.load_mar      = 1'b1;
                ctl.marmux_sel    = 1'b1;
                ctl.imm_sel       = is_load ? IMM_I : IMM_S;
                ctl.load_data_out = !is_load;
                state_next        = is_load ? LD1 : ST1;
            end
            LD1: begin
                ctl.mem_read = 1'b1;
                ctl.load_mdr = 1'b1;
                if (mem_resp)       state_next = LD2;
                else if (timed_out) state_next = TRAP;
            end
            LD2: begin
                ctl.load_regfile   = 1'b1;
                ctl.regfilemux_sel = RF_MDR;
                ctl.load_pc        = 1'b1;
                state_next         = FETCH1;
            end
            ST1: begin
                ctl.mem_write = 1'b1;
                case (funct3)
                    3'b000:  ctl.mem_byte_en = 4'b0001;
                    3'b001:  ctl.mem_byte_en = 4'b0011;
                    default: ctl.mem_byte_en = 4'b1111;
                endcase
                if (mem_resp)       state_next = ST2;
                else if (timed_out) state_next = TRAP;
            end
            ST2: begin
                ctl.load_pc = 1'b1;
                state_next  = FETCH1;
            end
            TRAP: begin
                ctl.trap = 1'b1;
            end
            default: begin
                state_next = FETCH1;
            end
        endcase
    end

    // Reset blanks every output combinationally so strobes drop in the reset cycle.
    assign ctl_out = rst ? '0 : ctl;

    assign load_pc        = ctl_out.load_pc;
    assign load_ir        = ctl_out.load_ir;
    assign load_regfile   = ctl_out.load_regfile;
    assign load_mar       = ctl_out.load_mar;
    assign load_mdr       = ctl_out.load_mdr;
    assign load_data_out  = ctl_out.load_data_out;
    assign mem_read       = ctl_out.mem_read;
    assign mem_write      = ctl_out.mem_write;
    assign mem_byte_en    = ctl_out.mem_byte_en;
    assign pcmux_sel      = ctl_out.pcmux_sel;
    assign marmux_sel     = ctl_out.marmux_sel;
    assign alumux1_sel    = ctl_out.alumux1_sel;
    assign alumux2_sel    = ctl_out.alumux2_sel;
    assign imm_sel        = ctl_out.imm_sel;
    assign regfilemux_sel = ctl_out.regfilemux_sel;
    assign trap           = ctl_out.trap;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Bench for rv32i_mc_control: a table of per-instruction expectations,
// hand-written multi-cycle corner sequences, and randomized instructions
// checked cycle by cycle against a sequence-level reference model.
module tb_rv32i_mc_control;

    localparam int TO = 4;

    logic       clk, rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_en, mem_resp;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_en;
    logic [1:0] pcmux_sel;
    logic       marmux_sel, alumux1_sel, alumux2_sel;
    logic [2:0] imm_sel, regfilemux_sel;
    logic       trap;

    rv32i_mc_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_en(br_en),
        .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_data_out(load_data_out), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_en(mem_byte_en), .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel),
        .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .imm_sel(imm_sel),
        .regfilemux_sel(regfilemux_sel), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
        logic       mem_read, mem_write;
        logic [3:0] mem_byte_en;
        logic [1:0] pcmux_sel;
        logic       marmux_sel, alumux1_sel, alumux2_sel;
        logic [2:0] imm_sel, regfilemux_sel;
        logic       trap;
    } ctl_t;

    typedef struct { ctl_t exp; bit resp; } cyc_t;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; bit br; int fw; int mw;
        int exp_len; int exp_strobe; logic [8:0] exp_key;  // key = {imm_sel, regfilemux_sel, pcmux_sel, load_regfile} of last cycle
    } vec_t;

    int tests = 0;
    int fails = 0;
    cyc_t mq[$];
    logic [6:0] legal [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    logic [6:0] h_op;
    logic [2:0] h_f3;
    bit         h_br;

    function automatic ctl_t sample();
        ctl_t c;
        c.load_pc = load_pc; c.load_ir = load_ir; c.load_regfile = load_regfile;
        c.load_mar = load_mar; c.load_mdr = load_mdr; c.load_data_out = load_data_out;
        c.mem_read = mem_read; c.mem_write = mem_write; c.mem_byte_en = mem_byte_en;
        c.pcmux_sel = pcmux_sel; c.marmux_sel = marmux_sel; c.alumux1_sel = alumux1_sel;
        c.alumux2_sel = alumux2_sel; c.imm_sel = imm_sel; c.regfilemux_sel = regfilemux_sel;
        c.trap = trap;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [6:0] op, input logic [2:0] f3,
                         input bit br, input bit resp);
        @(negedge clk);
        rst = r; opcode = op; funct3 = f3; br_en = br; mem_resp = resp;
        #1;
    endtask

    task automatic hstep(input bit r, input bit resp);
        drive(r, h_op, h_f3, h_br, resp);
    endtask

    task automatic rst_cycle(input string name);
        hstep(1'b1, 1'b1);
        chk(name, 32'(sample()), 32'd0);
    endtask

    // ---------------- reference model: expected per-cycle output sequence ----------------
    function automatic void add(input ctl_t c, input bit r);
        cyc_t e;
        e.exp = c; e.resp = r;
        mq.push_back(e);
    endfunction

    function automatic void add_trap();
        ctl_t t = '0;
        t.trap = 1'b1;
        repeat (3) add(t, 1'($urandom_range(0, 1)));
    endfunction

    // A memory access that answers after w idle cycles; past the timeout it traps.
    function automatic bit add_wait(input ctl_t c, input int w);
        int n = (w < TO) ? w : TO;
        for (int i = 0; i < n; i++) add(c, 1'b0);
        if (w >= TO) begin
            add_trap();
            return 1'b1;
        end
        add(c, 1'b1);
        return 1'b0;
    endfunction

    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input bit br,
                                  input int fw, input int mw);
        ctl_t c;
        logic [2:0] slt;
        mq.delete();
        slt = (f3 == 3'd2 || f3 == 3'd3) ? 3'd1 : 3'd0;
        c = '0; c.load_mar = 1; add(c, 1'($urandom_range(0, 1)));
        c = '0; c.mem_read = 1; c.load_mdr = 1;
        if (add_wait(c, fw)) return;
        c = '0; c.load_ir = 1; add(c, 1'($urandom_range(0, 1)));
        c = '0; add(c, 1'($urandom_range(0, 1)));
        c = '0;
        case (op)
            7'b0110111: begin c.load_regfile = 1; c.regfilemux_sel = 2; c.imm_sel = 1; c.load_pc = 1; add(c, 1'b1); end
            7'b0010111: begin c.alumux1_sel = 1; c.imm_sel = 1; c.load_regfile = 1; c.load_pc = 1; add(c, 1'b0); end
            7'b0010011: begin c.load_regfile = 1; c.load_pc = 1; c.regfilemux_sel = slt; add(c, 1'b1); end
            7'b0110011: begin c.alumux2_sel = 1; c.load_regfile = 1; c.load_pc = 1; c.regfilemux_sel = slt; add(c, 1'b0); end
            7'b1100011: begin c.alumux1_sel = 1; c.imm_sel = 2; c.load_pc = 1; c.pcmux_sel = br ? 2'd1 : 2'd0; add(c, 1'b1); end
            7'b1101111: begin c.alumux1_sel = 1; c.imm_sel = 4; c.load_regfile = 1; c.regfilemux_sel = 4; c.load_pc = 1; c.pcmux_sel = 1; add(c, 1'b1); end
            7'b1100111: begin c.load_regfile = 1; c.regfilemux_sel = 4; c.load_pc = 1; c.pcmux_sel = 2; add(c, 1'b0); end
            7'b0000011: begin
                c.load_mar = 1; c.marmux_sel = 1; add(c, 1'b1);
                c = '0; c.mem_read = 1; c.load_mdr = 1;
                if (add_wait(c, mw)) return;
                c = '0; c.load_regfile = 1; c.regfilemux_sel = 3; c.load_pc = 1; add(c, 1'b1);
            end
            7'b0100011: begin
                c.load_mar = 1; c.marmux_sel = 1; c.imm_sel = 3; c.load_data_out = 1; add(c, 1'b1);
                c = '0; c.mem_write = 1;
                c.mem_byte_en = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
                if (add_wait(c, mw)) return;
                c = '0; c.load_pc = 1; add(c, 1'b1);
            end
            default: add_trap();
        endcase
    endfunction

    task automatic run_model(input int n, input logic [6:0] op, input logic [2:0] f3,
                             input bit br, input int fw, input int mw);
        build(op, f3, br, fw, mw);
        for (int i = 0; i < mq.size(); i++) begin
            drive(1'b0, op, f3, br, mq[i].resp);
            chk($sformatf("rnd%0d_op%b_cyc%0d", n, op, i), 32'(sample()), 32'(mq[i].exp));
        end
        if (mq[mq.size() - 1].exp.trap) begin
            drive(1'b1, op, f3, br, 1'b0);
            chk($sformatf("rnd%0d_trap_reset", n), 32'(sample()), 32'd0);
        end
    endtask

    // ---------------- table vectors: length, strobe count, last-cycle selects ----------------
    task automatic run_vec(input int idx, input vec_t v);
        ctl_t cur, prev;
        int len = 0, strobes = 0, wc = 0, grp = 0;
        bit done = 0;
        prev = '0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            drive(1'b0, v.op, v.f3, v.br, 1'b0);
            cur = sample();
            if (cyc > 0 && cur.load_mar && !cur.marmux_sel) begin
                done = 1;
                rst = 1'b1;  // park in FETCH1 for the next vector
            end else begin
                if (cur.mem_read || cur.mem_write) begin
                    strobes++;
                    mem_resp = (wc >= ((grp == 0) ? v.fw : v.mw));
                    wc++;
                end else if (wc != 0) begin
                    grp++;
                    wc = 0;
                end
                prev = cur;
                len++;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL vec%0d_timeout: no return to FETCH1 within 40 cycles", idx);
            drive(1'b1, v.op, v.f3, v.br, 1'b0);
        end else begin
            chk($sformatf("vec%0d_len", idx), 32'(len), 32'(v.exp_len));
            chk($sformatf("vec%0d_strobes", idx), 32'(strobes), 32'(v.exp_strobe));
            chk($sformatf("vec%0d_last_sel", idx),
                32'({prev.imm_sel, prev.regfilemux_sel, prev.pcmux_sel, prev.load_regfile}),
                32'(v.exp_key));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[13];
        ctl_t f1, f2, tr;
        vt[0]  = '{7'b0010011, 3'd0, 1'b0, 0, 0, 5, 1, 9'b000_000_00_1};
        vt[1]  = '{7'b0010011, 3'd2, 1'b0, 0, 0, 5, 1, 9'b000_001_00_1};
        vt[2]  = '{7'b0110011, 3'd3, 1'b0, 0, 0, 5, 1, 9'b000_001_00_1};
        vt[3]  = '{7'b0110111, 3'd0, 1'b0, 0, 0, 5, 1, 9'b001_010_00_1};
        vt[4]  = '{7'b0010111, 3'd0, 1'b0, 0, 0, 5, 1, 9'b001_000_00_1};
        vt[5]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 5, 1, 9'b010_000_01_0};
        vt[6]  = '{7'b1100011, 3'd0, 1'b0, 0, 0, 5, 1, 9'b010_000_00_0};
        vt[7]  = '{7'b1101111, 3'd0, 1'b0, 0, 0, 5, 1, 9'b100_100_01_1};
        vt[8]  = '{7'b1100111, 3'd0, 1'b0, 0, 0, 5, 1, 9'b000_100_10_1};
        vt[9]  = '{7'b0000011, 3'd2, 1'b0, 0, 0, 7, 2, 9'b000_011_00_1};
        vt[10] = '{7'b0100011, 3'd1, 1'b0, 0, 3, 10, 5, 9'b000_000_00_0};
        vt[11] = '{7'b0000011, 3'd0, 1'b0, 2, 1, 10, 5, 9'b000_011_00_1};
        vt[12] = '{7'b0110011, 3'd0, 1'b0, 1, 0, 6, 2, 9'b000_000_00_1};

        f1 = '0; f1.load_mar = 1;
        f2 = '0; f2.mem_read = 1; f2.load_mdr = 1;
        tr = '0; tr.trap = 1;

        rst = 1; opcode = '0; funct3 = '0; br_en = 0; mem_resp = 0;
        h_op = 7'b0010011; h_f3 = 3'd0; h_br = 1'b0;

        // reset held two cycles with busy inputs: everything low
        h_op = 7'b0100011; h_br = 1'b1;
        rst_cycle("reset_c0");
        rst_cycle("reset_c1");

        foreach (vt[i]) run_vec(i, vt[i]);

        // store, response after 3 idle cycles
        h_op = 7'b0100011; h_f3 = 3'd1; h_br = 1'b0;
        hstep(0, 0); chk("st_fetch1", 32'(sample()), 32'(f1));
        hstep(0, 1); hstep(0, 0); hstep(0, 0);
        hstep(0, 0);
        chk("st_calc_imm", 32'(imm_sel), 32'd3);
        chk("st_calc_ldo", 32'({load_data_out, load_mar, marmux_sel}), 32'b111);
        for (int i = 0; i < 4; i++) begin
            hstep(0, (i == 3));
            chk($sformatf("st1_wait%0d", i), 32'({mem_write, mem_read, mem_byte_en}), 32'b10_0011);
        end
        hstep(0, 0); chk("st2_loadpc", 32'({load_pc, mem_write}), 32'b10);
        hstep(0, 0); chk("st_back_fetch1", 32'(sample()), 32'(f1));
        rst_cycle("st_reset");

        // illegal opcode traps and stays trapped until reset
        h_op = 7'b1111111;
        hstep(0, 1); hstep(0, 1); hstep(0, 0); hstep(0, 1);
        for (int i = 0; i < 5; i++) begin
            h_op = legal[$urandom_range(0, 8)];
            hstep(0, 1'($urandom_range(0, 1)));
            chk($sformatf("trap_hold%0d", i), 32'(sample()), 32'(tr));
        end
        rst_cycle("trap_reset");
        hstep(0, 0); chk("trap_exit_fetch1", 32'(sample()), 32'(f1));
        rst_cycle("trap_reset2");

        // fetch never answered: 4 wait cycles then TRAP
        h_op = 7'b0010011;
        hstep(0, 1);
        for (int i = 0; i < TO; i++) begin
            hstep(0, 0);
            chk($sformatf("to_fetch2_%0d", i), 32'(sample()), 32'(f2));
        end
        hstep(0, 1); chk("to_trap", 32'(sample()), 32'(tr));
        rst_cycle("to_reset");

        // reset in the middle of a load read
        h_op = 7'b0000011; h_f3 = 3'd2;
        hstep(0, 0); hstep(0, 1); hstep(0, 0); hstep(0, 0);
        hstep(0, 0); chk("ld_calc", 32'({load_mar, marmux_sel, imm_sel}), 32'b11_000);
        hstep(0, 0); chk("ld1_wait0", 32'(sample()), 32'(f2));
        hstep(0, 0); chk("ld1_wait1", 32'(sample()), 32'(f2));
        hstep(1, 0); chk("ld1_rst_drop", 32'(sample()), 32'd0);
        hstep(0, 0); chk("ld1_rst_fetch1", 32'(sample()), 32'(f1));
        rst_cycle("ld_reset");

        // randomized instructions against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            int fw, mw;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
            run_model(n, op, 3'($urandom), 1'($urandom), fw, mw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
